// File: rtl/packet_arbiter_rr.sv
// Round-robin packet arbiter: merges NUM_CH valid/ready byte streams onto one registered output,
// holding each grant from SoP to EoP. Define ARB_TIMEOUT_EN to release a locked channel idle for TIMEOUT cycles.
module packet_arbiter_rr #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 1024,
   localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     ipClk,
   input  logic                     ipReset,
   input  logic [NUM_CH*DATA_W-1:0] ipTxData,
   input  logic [NUM_CH-1:0]        ipTxValid,
   input  logic [NUM_CH-1:0]        ipTxSoP,
   input  logic [NUM_CH-1:0]        ipTxEoP,
   output logic [NUM_CH-1:0]        opTxReady,
   output logic [DATA_W-1:0]        opTxData,
   output logic                     opTxValid,
   output logic                     opTxSoP,
   output logic                     opTxEoP,
   input  logic                     ipTxReady,
   output logic [GW-1:0]            opGrant,
   output logic                     opBusy,
   output logic                     opTimeout,
   output logic                     opState
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} stateT;

   localparam logic [GW:0] NCH = (GW+1)'(NUM_CH);

   stateT             state;
   logic [GW-1:0]     grant;
   logic [GW-1:0]     lastGrant;
   logic [GW-1:0]     winner;
   logic [GW:0]       scanIdx;
   logic              anyReq;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] txReady;
   logic [DATA_W-1:0] grantData;
   logic              grantValid;
   logic              grantSoP;
   logic              grantEoP;
   logic [DATA_W-1:0] outData;
   logic              outValid;
   logic              outSoP;
   logic              outEoP;
   logic              outFree;
   logic              inXfer;

   // Handshake: a beat moves on any port when its valid and ready are both high at the clock edge;
   // valid never waits for ready, and the output beat holds steady while opTxValid && !ipTxReady.
   assign req     = ipTxValid & ipTxSoP;
   assign outFree = !outValid || ipTxReady;
   assign inXfer  = (state == LOCKED) && grantValid && outFree;

   // Scan starts one past the previous owner so every requester is reached within one rotation.
   always_comb begin
      winner  = lastGrant;
      anyReq  = 1'b0;
      scanIdx = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         scanIdx = {1'b0, lastGrant} + (GW+1)'(k);
         if (scanIdx >= NCH) scanIdx = scanIdx - NCH;
         if (!anyReq && req[scanIdx[GW-1:0]]) begin
            anyReq = 1'b1;
            winner = scanIdx[GW-1:0];
         end
      end
   end

   always_comb begin
      grantData  = '0;
      grantValid = 1'b0;
      grantSoP   = 1'b0;
      grantEoP   = 1'b0;
      txReady    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant == GW'(i)) begin
            grantData  = ipTxData[i*DATA_W +: DATA_W];
            grantValid = ipTxValid[i];
            grantSoP   = ipTxSoP[i];
            grantEoP   = ipTxEoP[i];
         end
         // In IDLE, beats without SoP are orphans and are drained so a desynchronised source cannot stall.
         if (state == LOCKED) txReady[i] = (grant == GW'(i)) && outFree;
         else                 txReady[i] = ipTxValid[i] && !ipTxSoP[i];
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] idleCnt;
   logic          timeoutPulse;
`endif

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         state     <= IDLE;
         grant     <= '0;
         lastGrant <= GW'(NUM_CH - 1);
         outData   <= '0;
         outValid  <= 1'b0;
         outSoP    <= 1'b0;
         outEoP    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         idleCnt      <= '0;
         timeoutPulse <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         timeoutPulse <= 1'b0;
`endif
         if (inXfer) begin
            outData  <= grantData;
            outSoP   <= grantSoP;
            outEoP   <= grantEoP;
            outValid <= 1'b1;
         end else if (ipTxReady) begin
            outValid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (anyReq) begin
                  grant <= winner;
                  state <= LOCKED;
`ifdef ARB_TIMEOUT_EN
                  idleCnt <= '0;
`endif
               end
            end
            LOCKED: begin
               if (inXfer && grantEoP) begin
                  state     <= IDLE;
                  lastGrant <= grant;
               end
`ifdef ARB_TIMEOUT_EN
               else if (inXfer) begin
                  idleCnt <= '0;
               end else if (!grantValid) begin
                  // Only source silence counts; downstream back-pressure with the source valid does not.
                  if (idleCnt == CW'(TIMEOUT - 1)) begin
                     state        <= IDLE;
                     lastGrant    <= grant;
                     timeoutPulse <= 1'b1;
                     idleCnt      <= '0;
                  end else begin
                     idleCnt <= idleCnt + 1'b1;
                  end
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ARB_TIMEOUT_EN
   assign opTimeout = timeoutPulse;
`else
   assign opTimeout = 1'b0;
`endif

   assign opTxReady = ipReset ? '0 : txReady;
   assign opTxData  = outData;
   assign opTxValid = outValid;
   assign opTxSoP   = outSoP;
   assign opTxEoP   = outEoP;
   assign opGrant   = grant;
   assign opBusy    = (state == LOCKED);
   assign opState   = state;

endmodule

// File: tb/tb_packet_arbiter_rr.sv
// Directed bench for packet_arbiter_rr: queued channel sources, output beat scoreboard and per-scenario checks.
module tb_packet_arbiter_rr;
   localparam int NUM_CH  = 4;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 16;
   localparam int GW      = 2;

   logic                     clk;
   logic                     ipReset;
   logic [NUM_CH*DATA_W-1:0] ipTxData;
   logic [NUM_CH-1:0]        ipTxValid;
   logic [NUM_CH-1:0]        ipTxSoP;
   logic [NUM_CH-1:0]        ipTxEoP;
   logic [NUM_CH-1:0]        opTxReady;
   logic [DATA_W-1:0]        opTxData;
   logic                     opTxValid;
   logic                     opTxSoP;
   logic                     opTxEoP;
   logic                     ipTxReady;
   logic [GW-1:0]            opGrant;
   logic                     opBusy;
   logic                     opTimeout;
   logic                     opState;

   int nVec = 0;
   int nErr = 0;

   // Beats are packed {sop, eop, data}.
   logic [DATA_W+1:0] srcQ [NUM_CH][$];
   logic [DATA_W+1:0] expQ [$];
   logic [DATA_W+1:0] head;
   logic [NUM_CH-1:0] taken;

   packet_arbiter_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .ipClk(clk), .ipReset(ipReset), .ipTxData(ipTxData), .ipTxValid(ipTxValid),
      .ipTxSoP(ipTxSoP), .ipTxEoP(ipTxEoP), .opTxReady(opTxReady), .opTxData(opTxData),
      .opTxValid(opTxValid), .opTxSoP(opTxSoP), .opTxEoP(opTxEoP), .ipTxReady(ipTxReady),
      .opGrant(opGrant), .opBusy(opBusy), .opTimeout(opTimeout), .opState(opState)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Channel sources: present queue heads, pop when the beat was accepted at the previous edge.
   always begin
      @(negedge clk);
      #3;
      taken = ipTxValid & opTxReady;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (taken[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
         if (srcQ[i].size() > 0) begin
            head = srcQ[i][0];
            ipTxValid[i] = 1'b1;
            ipTxSoP[i]   = head[DATA_W+1];
            ipTxEoP[i]   = head[DATA_W];
            ipTxData[i*DATA_W +: DATA_W] = head[DATA_W-1:0];
         end else begin
            ipTxValid[i] = 1'b0;
            ipTxSoP[i]   = 1'b0;
            ipTxEoP[i]   = 1'b0;
            ipTxData[i*DATA_W +: DATA_W] = '0;
         end
      end
   end

   // Scoreboard: every visible output beat must match the expected head; pop on transfer.
   always begin
      @(negedge clk);
      #2;
      if (!ipReset && opTxValid === 1'b1) begin
         nVec++;
         if (expQ.size() == 0) begin
            nErr++;
            $display("FAIL out_unexpected: got beat %b_%b_%h, expected no beat", opTxSoP, opTxEoP, opTxData);
         end else begin
            if ({opTxSoP, opTxEoP, opTxData} !== expQ[0]) begin
               nErr++;
               $display("FAIL out_beat: got %b_%b_%h, expected %b_%b_%h", opTxSoP, opTxEoP, opTxData,
                        expQ[0][DATA_W+1], expQ[0][DATA_W], expQ[0][DATA_W-1:0]);
            end
            if (ipTxReady) void'(expQ.pop_front());
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pushBeat(input int ch, input logic sop, input logic eop, input logic [DATA_W-1:0] d,
                           input bit expected);
      srcQ[ch].push_back({sop, eop, d});
      if (expected) expQ.push_back({sop, eop, d});
   endtask

   task automatic waitDrain(input int budget, output bit drained);
      for (int k = 0; k < budget && expQ.size() > 0; k++) tick();
      drained = (expQ.size() == 0);
   endtask

   task automatic applyReset();
      ipReset = 1'b1;
      for (int i = 0; i < NUM_CH; i++) srcQ[i].delete();
      expQ.delete();
      tick();
      tick();
      ipReset = 1'b0;
      tick();
   endtask

   // Scenarios
   task automatic test_reset();
      ipReset = 1'b1;
      tick();
      tick();
      nVec++;
      if (opTxReady !== 4'b0000 || opTxValid !== 1'b0 || opBusy !== 1'b0 || opGrant !== 2'd0) begin
         nErr++;
         $display("FAIL reset_hold: got ready=%b valid=%b busy=%b grant=%0d, expected 0000/0/0/0",
                  opTxReady, opTxValid, opBusy, opGrant);
      end
      ipReset = 1'b0;
      tick();
      nVec++;
      if ({opTxSoP, opTxEoP, opTxData, opTimeout, opState} !== 12'h000) begin
         nErr++;
         $display("FAIL reset_state: got sop=%b eop=%b data=%h timeout=%b state=%b, expected all 0",
                  opTxSoP, opTxEoP, opTxData, opTimeout, opState);
      end
   endtask

   task automatic test_single_packet();
      bit drained;
      pushBeat(2, 1'b1, 1'b0, 8'hA1, 1'b1);
      pushBeat(2, 1'b0, 1'b0, 8'hA2, 1'b1);
      pushBeat(2, 1'b0, 1'b1, 8'hA3, 1'b1);
      tick();
      nVec++;
      if (ipTxValid[2] !== 1'b1 || opTxReady !== 4'b0000 || opBusy !== 1'b0) begin
         nErr++;
         $display("FAIL arb_latency: got valid2=%b ready=%b busy=%b, expected 1/0000/0", ipTxValid[2], opTxReady, opBusy);
      end
      tick();
      nVec++;
      if (opBusy !== 1'b1 || opGrant !== 2'd2 || opTxReady !== 4'b0100 || opTxValid !== 1'b0) begin
         nErr++;
         $display("FAIL grant_ch2: got busy=%b grant=%0d ready=%b valid=%b, expected 1/2/0100/0",
                  opBusy, opGrant, opTxReady, opTxValid);
      end
      tick();
      nVec++;
      if (opTxValid !== 1'b1 || opTxSoP !== 1'b1 || opTxEoP !== 1'b0) begin
         nErr++;
         $display("FAIL first_beat: got valid=%b sop=%b eop=%b, expected 1/1/0", opTxValid, opTxSoP, opTxEoP);
      end
      tick();
      tick();
      nVec++;
      if (opBusy !== 1'b0 || opTxValid !== 1'b1 || opTxEoP !== 1'b1 || opTxData !== 8'hA3) begin
         nErr++;
         $display("FAIL eop_release: got busy=%b valid=%b eop=%b data=%h, expected 0/1/1/a3",
                  opBusy, opTxValid, opTxEoP, opTxData);
      end
      waitDrain(20, drained);
      nVec++;
      if (!drained) begin
         nErr++;
         $display("FAIL single_drain: got %0d beats pending, expected 0", expQ.size());
      end
      tick();
   endtask

   task automatic test_round_robin();
      bit drained;
      applyReset();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < NUM_CH; c++)
            for (int b = 0; b < 2; b++)
               pushBeat(c, b == 0, b == 1, 8'(16*c + 4*r + b), 1'b1);
      waitDrain(200, drained);
      nVec++;
      if (!drained) begin
         nErr++;
         $display("FAIL rr_drain: got %0d beats pending, expected 0", expQ.size());
      end
      tick();
      nVec++;
      if (opGrant !== 2'd3 || opBusy !== 1'b0 || opTxValid !== 1'b0) begin
         nErr++;
         $display("FAIL rr_end: got grant=%0d busy=%b valid=%b, expected 3/0/0", opGrant, opBusy, opTxValid);
      end
   endtask

   task automatic test_stall();
      bit drained;
      bit seen;
      pushBeat(1, 1'b1, 1'b0, 8'hB1, 1'b1);
      pushBeat(1, 1'b0, 1'b0, 8'hB2, 1'b1);
      pushBeat(1, 1'b0, 1'b1, 8'hB3, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         seen = (opBusy === 1'b1 && opGrant === 2'd1);
      end
      nVec++;
      if (!seen) begin
         nErr++;
         $display("FAIL stall_grant: got busy=%b grant=%0d, expected 1/1", opBusy, opGrant);
      end
      pushBeat(0, 1'b1, 1'b0, 8'hC1, 1'b1);
      pushBeat(0, 1'b0, 1'b1, 8'hC2, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         seen = (opTxValid === 1'b1);
      end
      ipTxReady = 1'b0;
      #1;
      nVec++;
      if (!seen || opTxData !== 8'hB1 || opTxReady !== 4'b0000) begin
         nErr++;
         $display("FAIL stall_enter: got valid=%b data=%h ready=%b, expected 1/b1/0000", opTxValid, opTxData, opTxReady);
      end
      tick();
      nVec++;
      if (opTxValid !== 1'b1 || opTxData !== 8'hB1 || opTxSoP !== 1'b1 || opTxReady !== 4'b0000) begin
         nErr++;
         $display("FAIL stall_hold: got valid=%b data=%h sop=%b ready=%b, expected 1/b1/1/0000",
                  opTxValid, opTxData, opTxSoP, opTxReady);
      end
      ipTxReady = 1'b1;
      waitDrain(50, drained);
      nVec++;
      if (!drained) begin
         nErr++;
         $display("FAIL stall_drain: got %0d beats pending, expected 0", expQ.size());
      end
      tick();
      nVec++;
      if (opGrant !== 2'd0 || opBusy !== 1'b0) begin
         nErr++;
         $display("FAIL stall_end: got grant=%0d busy=%b, expected 0/0", opGrant, opBusy);
      end
   endtask

   task automatic test_back_to_back();
      bit drained;
      bit seen;
      pushBeat(3, 1'b1, 1'b1, 8'h55, 1'b1);
      pushBeat(3, 1'b1, 1'b1, 8'h66, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         seen = (opTxValid === 1'b1 && opTxData === 8'h55);
      end
      nVec++;
      if (!seen || opBusy !== 1'b0 || opGrant !== 2'd3) begin
         nErr++;
         $display("FAIL single_beat: got seen=%b busy=%b grant=%0d, expected 1/0/3", seen, opBusy, opGrant);
      end
      tick();
      nVec++;
      if (opTxValid !== 1'b0 || opBusy !== 1'b1 || opGrant !== 2'd3) begin
         nErr++;
         $display("FAIL idle_gap: got valid=%b busy=%b grant=%0d, expected 0/1/3", opTxValid, opBusy, opGrant);
      end
      tick();
      nVec++;
      if (opTxValid !== 1'b1 || opTxData !== 8'h66 || opBusy !== 1'b0) begin
         nErr++;
         $display("FAIL second_single: got valid=%b data=%h busy=%b, expected 1/66/0", opTxValid, opTxData, opBusy);
      end
      waitDrain(20, drained);
      nVec++;
      if (!drained) begin
         nErr++;
         $display("FAIL b2b_drain: got %0d beats pending, expected 0", expQ.size());
      end
      tick();
   endtask

   task automatic test_orphan();
      pushBeat(1, 1'b0, 1'b0, 8'h77, 1'b0);
      tick();
      nVec++;
      if (ipTxValid[1] !== 1'b1 || opTxReady !== 4'b0010 || opTxValid !== 1'b0) begin
         nErr++;
         $display("FAIL orphan_ready: got valid1=%b ready=%b outvalid=%b, expected 1/0010/0",
                  ipTxValid[1], opTxReady, opTxValid);
      end
      tick();
      nVec++;
      if (ipTxValid[1] !== 1'b0 || opTxValid !== 1'b0 || opBusy !== 1'b0) begin
         nErr++;
         $display("FAIL orphan_drop: got valid1=%b outvalid=%b busy=%b, expected 0/0/0",
                  ipTxValid[1], opTxValid, opBusy);
      end
   endtask

   task automatic test_reset_mid_packet();
      bit seen;
      pushBeat(0, 1'b1, 1'b0, 8'hD1, 1'b0);
      pushBeat(0, 1'b0, 1'b0, 8'hD2, 1'b0);
      pushBeat(0, 1'b0, 1'b1, 8'hD3, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         seen = (opTxValid === 1'b1);
      end
      nVec++;
      if (!seen || opBusy !== 1'b1 || opGrant !== 2'd0) begin
         nErr++;
         $display("FAIL mid_setup: got valid=%b busy=%b grant=%0d, expected 1/1/0", opTxValid, opBusy, opGrant);
      end
      ipReset = 1'b1;
      srcQ[0].delete();
      tick();
      nVec++;
      if ({opTxValid, opTxSoP, opTxEoP, opTxData, opBusy, opGrant, opTxReady, opTimeout, opState} !== 19'h0) begin
         nErr++;
         $display("FAIL mid_reset: got valid=%b sop=%b eop=%b data=%h busy=%b grant=%0d ready=%b timeout=%b state=%b, expected all 0",
                  opTxValid, opTxSoP, opTxEoP, opTxData, opBusy, opGrant, opTxReady, opTimeout, opState);
      end
      ipReset = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      bit drained;
      bit found;
      logic expPulse;
      pushBeat(0, 1'b1, 1'b0, 8'hE1, 1'b1);
`ifdef ARB_TIMEOUT_EN
      pushBeat(1, 1'b1, 1'b0, 8'hF1, 1'b1);
      pushBeat(1, 1'b0, 1'b1, 8'hF2, 1'b1);
`else
      pushBeat(1, 1'b1, 1'b0, 8'hF1, 1'b0);
      pushBeat(1, 1'b0, 1'b1, 8'hF2, 1'b0);
`endif
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         tick();
         found = (opTxReady[0] === 1'b1 && ipTxValid[0] === 1'b1);
      end
      nVec++;
      if (!found) begin
         nErr++;
         $display("FAIL to_grant0: got ready=%b, expected ch0 accepted", opTxReady);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         nVec++;
`ifdef ARB_TIMEOUT_EN
         expPulse = (k == 17);
         if (opTimeout !== expPulse) begin
            nErr++;
            $display("FAIL to_pulse[%0d]: got %b, expected %b", k, opTimeout, expPulse);
         end
`else
         expPulse = 1'b0;
         if (opTimeout !== expPulse || opBusy !== 1'b1 || opGrant !== 2'd0) begin
            nErr++;
            $display("FAIL to_locked[%0d]: got timeout=%b busy=%b grant=%0d, expected 0/1/0", k, opTimeout, opBusy, opGrant);
         end
`endif
      end
      waitDrain(40, drained);
      nVec++;
      if (!drained) begin
         nErr++;
         $display("FAIL to_drain: got %0d beats pending, expected 0", expQ.size());
      end
   endtask

   initial begin
      ipReset   = 1'b1;
      ipTxReady = 1'b1;
      ipTxData  = '0;
      ipTxValid = '0;
      ipTxSoP   = '0;
      ipTxEoP   = '0;
      test_reset();
      test_single_packet();
      test_round_robin();
      test_stall();
      test_back_to_back();
      test_orphan();
      test_reset_mid_packet();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

// File: doc/packet_arbiter_rr.md
Name: packet_arbiter_rr

Overview:
- Parametrised N-channel packet arbiter that merges UART_PACKET-style byte streams onto one downstream transmitter.
- Arbitration is round-robin at packet granularity. A grant is held from SoP through EoP, so packets never interleave.
- Uses a symmetric valid/ready handshake with one registered output stage.
- Sits between the channel packet builders and the UART TX block. Replaces the fixed two-input arbiter.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 8, payload width per beat.
- TIMEOUT, 1024, idle-cycle limit on a locked channel (used only with ARB_TIMEOUT_EN).

Ports:
- ipClk  in  1  system clock.
- ipReset  in  1  synchronous reset, active-high.
- ipTxData  in  NUM_CH*DATA_W  channel i payload at [i*DATA_W +: DATA_W].
- ipTxValid  in  NUM_CH  per-channel beat valid.
- ipTxSoP  in  NUM_CH  per-channel start-of-packet.
- ipTxEoP  in  NUM_CH  per-channel end-of-packet.
- opTxReady  out  NUM_CH  per-channel ready; a beat transfers when ipTxValid[i] && opTxReady[i].
- opTxData  out  DATA_W  merged payload.
- opTxValid  out  1  merged beat valid.
- opTxSoP  out  1  merged start-of-packet.
- opTxEoP  out  1  merged end-of-packet.
- ipTxReady  in  1  downstream ready; output transfers when opTxValid && ipTxReady.
- opGrant  out  max(1,$clog2(NUM_CH))  index of the current owner; meaningful while opBusy.
- opBusy  out  1  high while a packet is locked.
- opTimeout  out  1  one-cycle pulse on a timeout release; tied 0 when the feature is off.

Behaviour:
- Reset (sync, ipReset=1):
  - state=IDLE; last_grant=NUM_CH-1, so ch0 wins first.
  - opTxValid, opTxSoP, opTxEoP, opBusy, opTimeout = 0; opTxData = 0; opGrant = 0; opTxReady all 0.
  - Reset mid-packet discards the in-flight output beat and the grant. No recovery EoP is generated.
- IDLE:
  - req[i] = ipTxValid[i] && ipTxSoP[i].
  - Winner = first set req scanning last_grant+1, +2, ... modulo NUM_CH.
  - If any req: grant<=winner, state<=LOCKED. The SoP beat is not consumed this cycle (1-cycle arbitration latency).
  - Orphans: a channel with ipTxValid && !ipTxSoP gets opTxReady=1 and the beat is discarded. This prevents deadlock on a desynchronised source. Orphans are flushed only on channels with no req.
- LOCKED:
  - opTxReady[grant] = !opTxValid || ipTxReady (combinational); all other channels 0.
  - On an input transfer: the output register loads data, SoP, EoP and sets opTxValid=1.
  - Otherwise, when ipTxReady is high, opTxValid<=0.
  - Sustains one beat per cycle with ipTxReady held high.
  - SoP on a non-first beat of the locked channel is forwarded unchanged; EoP alone terminates the packet.
  - Accepted EoP beat: state<=IDLE, last_grant<=grant.
  - A single-beat packet (SoP && EoP) is accepted and releases in the same cycle.
- Inter-packet gap:
  - Minimum one IDLE cycle between packets.
  - The output register may still hold the previous EoP beat during IDLE. Arbitration proceeds, and the new owner stalls until the register frees.
- Simultaneous SoP on all channels: served in order last_grant+1, +2, ... Each channel gets exactly one packet per rotation.
- Output stability: while opTxValid && !ipTxReady, opTxData, opTxSoP and opTxEoP hold constant.
- Status outputs: opBusy = (state==LOCKED), registered. opGrant is a register, updated on grant only.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - In LOCKED, a counter increments each cycle that ipTxValid[grant]==0.
  - The counter clears on any accepted beat and on entry to LOCKED.
  - Cycles stalled by ipTxReady=0 with the source valid do not count.
  - When the count reaches TIMEOUT-1: state<=IDLE, last_grant<=grant, opTimeout=1 for one cycle. The downstream packet is left without an EoP.
- Without the macro: no counter logic; opTimeout is constant 0; a lock persists until EoP.

Test Plan:
- Reset then ch2 sends 3-beat packet 0xA1(SoP), 0xA2, 0xA3(EoP), ipTxReady=1 -> opTxReady[2] rises 1 cycle after SoP; output shows A1,A2,A3 on consecutive cycles with SoP/EoP aligned; opBusy low after EoP.
- All 4 channels present SoP simultaneously after reset, 2-beat packets each -> output order ch0,ch1,ch2,ch3. Repeat -> ch0 again. No interleaving of beats.
- ch1 locked mid-packet while ch0 asserts SoP; toggle ipTxReady 1,0,0,1 -> output holds the beat during stalls with no data change; ch0 served only after ch1 EoP.
- Single-beat packet (SoP&EoP, 0x55) on ch3, then immediate SoP on ch3 -> two packets delivered with one IDLE gap; last_grant=3 between them.
- Orphan: ch1 presents Valid without SoP in IDLE (0x77) -> opTxReady[1]=1, beat dropped, opTxValid stays 0. Assert ipReset mid-packet on ch0 -> next cycle all outputs 0, state IDLE.
- ARB_TIMEOUT_EN, TIMEOUT=16: ch0 sends SoP then drops Valid -> opTimeout pulses 1 cycle, 16 cycles after the last accepted beat. Pending ch1 SoP is granted on the following arbitration. Without the macro, ch0 stays locked and opTimeout stays 0.
